// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch controller: state encoding and BCD digit geometry.
package stopwatch_pkg;

    localparam int STATE_W = 3;
    localparam int DIGIT_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_STOP = 3'd2,
        S_INC  = 3'd3,
        S_TRAP = 3'd4,
        S_LAP  = 3'd5
    } state_e;

    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    function automatic logic is_counting(state_e s);
        return (s == S_RUN) || (s == S_LAP);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the time counter; carry_out enables the next digit up.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en_in,
    output logic [DIGIT_W-1:0] q,
    output logic               carry_out
);

    logic [DIGIT_W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en_in) begin
            q_d = (q_q == DIGIT_MAX) ? '0 : q_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q         = q_q;
    assign carry_out = en_in & (q_q == DIGIT_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: input edge detection, control FSM, run prescaler,
// lap hold register and a chained BCD time counter.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  inc,
    input  logic                  clr,
    input  logic                  lap,
    output logic                  time_en,
    output logic [4*DIGITS-1:0]   count,
    output logic [4*DIGITS-1:0]   disp,
    output logic [STATE_W-1:0]    state,
    output logic                  ovf
);

    localparam int PSC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_DIV - 1);

    logic [4:0]          in_vec, edges;
    logic [4:0]          prev_q, prev_d;
    logic                armed_q, armed_d;
    state_e              state_q, state_d;
    logic [PSC_W-1:0]    psc_q, psc_d;
    logic [4*DIGITS-1:0] lap_q, lap_d;
    logic                ovf_q, ovf_d;
    logic                e_start, e_stop, e_inc, e_clr, e_lap;
    logic                lap_cap, tick, cnt_en;
    logic [DIGITS:0]     en_chain;

    // armed_q masks the first cycle after reset so a level already high
    // at deassertion is absorbed into prev_q instead of reading as an edge.
    assign in_vec  = {lap, clr, inc, stop, start};
    assign edges   = in_vec & ~prev_q & {5{armed_q}};
    assign e_start = edges[0];
    assign e_stop  = edges[1];
    assign e_inc   = edges[2];
    assign e_clr   = edges[3];
    assign e_lap   = edges[4];

    assign time_en = is_counting(state_q);

    always_comb begin
        prev_d  = in_vec;
        armed_d = 1'b1;
        state_d = state_q;
        lap_cap = 1'b0;
        if (e_clr) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_STOP: begin
                    if (e_start)    state_d = S_RUN;
                    else if (e_inc) state_d = S_INC;
                end
                S_RUN: begin
                    if (e_stop) begin
                        state_d = S_STOP;
                    end else if (e_lap) begin
                        state_d = S_LAP;
                        lap_cap = 1'b1;
                    end
                end
                S_LAP: begin
                    if (e_stop)     state_d = S_STOP;
                    else if (e_lap) state_d = S_RUN;
                end
                S_INC:   state_d = S_TRAP;
                S_TRAP:  if (!inc) state_d = S_STOP;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Prescaler holds while stopped so a resumed run finishes the partial tick.
    always_comb begin
        psc_d = psc_q;
        tick  = 1'b0;
        if (e_clr) begin
            psc_d = '0;
        end else if (time_en) begin
            if (psc_q == PSC_LAST) begin
                psc_d = '0;
                tick  = 1'b1;
            end else begin
                psc_d = psc_q + 1'b1;
            end
        end
    end

    assign cnt_en      = tick | (state_q == S_INC);
    assign en_chain[0] = cnt_en;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (e_clr),
            .en_in     (en_chain[i]),
            .q         (count[4*i +: 4]),
            .carry_out (en_chain[i+1])
        );
    end

    always_comb begin
        lap_d = lap_q;
        if (e_clr)        lap_d = '0;
        else if (lap_cap) lap_d = count;
        ovf_d = en_chain[DIGITS] & ~e_clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= '0;
            armed_q <= 1'b0;
            state_q <= S_IDLE;
            psc_q   <= '0;
            lap_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            armed_q <= armed_d;
            state_q <= state_d;
            psc_q   <= psc_d;
            lap_q   <= lap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign disp  = (state_q == S_LAP) ? lap_q : count;
    assign state = state_q;
    assign ovf   = ovf_q;

endmodule
